e_mdu: RTL

E_MDU -- requirements
Module: e_mdu

---
 rtl/e_mdu.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU run for a fixed number of cycles and then write HI/LO.
// MTHI/MTLO write in a single cycle.
// Ports:
//   clk     - clock; all state changes on the rising edge
//   reset   - synchronous, active-low reset
//   start   - request valid from the E stage
//   mdu_op  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved
//   a_i     - forwarded rs operand
//   b_i     - forwarded rt operand
//   busy_o  - multi-cycle operation in flight (hazard unit stalls D/E)
//   done_o  - one-cycle pulse when a multi-cycle op updates HI/LO
//   hi_o    - HI register
//   lo_o    - LO register
module e_mdu #(
  parameter int unsigned MUL_CYC = 5,
  parameter int unsigned DIV_CYC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned CNT_MAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [2:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [CNT_W-1:0] cnt_q;

  logic signed [63:0] mult_s_c;
  logic [63:0]        mult_u_c;
  logic               div_zero_c;
  logic               div_ovf_c;
  logic [31:0]        sdiv_b_c;
  logic [31:0]        udiv_b_c;
  logic signed [31:0] sq_c;
  logic signed [31:0] sr_c;
  logic [31:0]        uq_c;
  logic [31:0]        ur_c;
  logic [31:0]        res_hi_c;
  logic [31:0]        res_lo_c;

  // Result of the latched operation, consumed at the completion edge.
  // Divisors are steered to 1 for the zero-divide and INT_MIN/-1 cases so the
  // dividers never see an undefined input; INT_MIN/1 already yields the
  // required overflow result (LO=INT_MIN, HI=0).
  always_comb begin
    mult_s_c   = 64'($signed(a_q)) * 64'($signed(b_q));
    mult_u_c   = 64'(a_q) * 64'(b_q);
    div_zero_c = (b_q == 32'd0);
    div_ovf_c  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    sdiv_b_c   = (div_zero_c || div_ovf_c) ? 32'd1 : b_q;
    udiv_b_c   = div_zero_c ? 32'd1 : b_q;
    sq_c       = $signed(a_q) / $signed(sdiv_b_c);
    sr_c       = $signed(a_q) % $signed(sdiv_b_c);
    uq_c       = a_q / udiv_b_c;
    ur_c       = a_q % udiv_b_c;
    res_hi_c   = hi_o;
    res_lo_c   = lo_o;
    case (op_q)
      OP_MULT: begin
        res_hi_c = mult_s_c[63:32];
        res_lo_c = mult_s_c[31:0];
      end
      OP_MULTU: begin
        res_hi_c = mult_u_c[63:32];
        res_lo_c = mult_u_c[31:0];
      end
      OP_DIV: begin
        res_hi_c = div_zero_c ? a_q : 32'(sr_c);
        res_lo_c = div_zero_c ? 32'hFFFF_FFFF : 32'(sq_c);
      end
      OP_DIVU: begin
        res_hi_c = div_zero_c ? a_q : ur_c;
        res_lo_c = div_zero_c ? 32'hFFFF_FFFF : uq_c;
      end
      default: ;
    endcase
  end

  // Request acceptance, cycle countdown and HI/LO update.
  // While busy, start is ignored, including at the completion edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
      hi_o   <= 32'd0;
      lo_o   <= 32'd0;
      cnt_q  <= '0;
      op_q   <= 3'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
    end else begin
      done_o <= 1'b0;
      if (busy_o) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_o <= 1'b0;
          done_o <= 1'b1;
          hi_o   <= res_hi_c;
          lo_o   <= res_lo_c;
        end
      end else if (start) begin
        case (mdu_op)
          OP_MULT, OP_MULTU: begin
            op_q   <= mdu_op;
            a_q    <= a_i;
            b_q    <= b_i;
            cnt_q  <= CNT_W'(MUL_CYC);
            busy_o <= 1'b1;
          end
          OP_DIV, OP_DIVU: begin
            op_q   <= mdu_op;
            a_q    <= a_i;
            b_q    <= b_i;
            cnt_q  <= CNT_W'(DIV_CYC);
            busy_o <= 1'b1;
          end
          OP_MTHI: hi_o <= a_i;
          OP_MTLO: lo_o <= a_i;
          default: ;
        endcase
      end
    end
  end

endmodule
